// File: rtl/credit_issuer.sv
// credit_issuer: N-wide in-order issue stage. Holds one bundle, issues the
// longest in-order prefix that fits the station/ROB credits, and keeps local
// credit counters that are replenished by release pulses from downstream.
module credit_issuer #(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_ST      = 4,
    parameter int ST_DEPTH    = 8,
    parameter int ROB_DEPTH   = 32,
    parameter int PAYLOAD_W   = 128,
    localparam int STW = $clog2(NUM_ST + 1),
    localparam int CW  = $clog2(ROB_DEPTH + 1),
    localparam int RW  = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [ISSUE_WIDTH-1:0]           in_valid,
    input  logic [ISSUE_WIDTH*STW-1:0]       in_st_type,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] in_payload,
    output logic                             in_ready,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [ISSUE_WIDTH*STW-1:0]       out_st_type,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_payload,
    input  logic [NUM_ST*RW-1:0]             st_release,
    input  logic [RW-1:0]                    rob_release,
    output logic [NUM_ST*CW-1:0]             st_credit,
    output logic [CW-1:0]                    rob_credit,
    output logic                             stop
);

    localparam int IW = ISSUE_WIDTH;
    localparam logic [CW-1:0] ST_FULL  = CW'(ST_DEPTH);
    localparam logic [CW-1:0] ROB_FULL = CW'(ROB_DEPTH);

    // Credit after this cycle's claims and releases, kept one bit wider so an
    // over-release is visible before saturation. Claims never exceed credit.
    function automatic logic [CW:0] credit_sum(input logic [CW-1:0] cur,
                                               input logic [CW-1:0] claim,
                                               input logic [RW-1:0] rel);
        credit_sum = {1'b0, cur} - {1'b0, claim} + (CW+1)'(rel);
    endfunction

    // Saturate a widened credit sum at the structure depth.
    function automatic logic [CW-1:0] credit_sat(input logic [CW:0]   sum,
                                                 input logic [CW-1:0] depth);
        credit_sat = (sum > {1'b0, depth}) ? depth : sum[CW-1:0];
    endfunction

    logic clear;
    assign clear = reset | flush;

    // Hold register (stage p0)
    logic [IW-1:0]        vld_p0;
    logic [STW-1:0]       type_p0 [IW];
    logic [PAYLOAD_W-1:0] pay_p0  [IW];

    // Issued slots (stage p1)
    logic [IW-1:0]        vld_p1;
    logic [STW-1:0]       type_p1 [IW];
    logic [PAYLOAD_W-1:0] pay_p1  [IW];
    logic                 stop_p1;

    // Credit counters
    logic [CW-1:0] st_cred [NUM_ST];
    logic [CW-1:0] rob_cred;

    // Issue decision and per-resource claims made this cycle
    logic [IW-1:0] issue;
    logic [CW-1:0] st_claim [NUM_ST];
    logic [CW-1:0] rob_claim;
    logic          stall;
    logic          accept;

    // In-order walk of the held bundle: a valid slot issues only if every earlier valid slot did
    always_comb begin
        logic blocked;
        logic fits;
        issue     = '0;
        rob_claim = '0;
        blocked   = 1'b0;
        fits      = 1'b0;
        for (int s = 0; s < NUM_ST; s++) st_claim[s] = '0;
        for (int j = 0; j < IW; j++) begin
            if (vld_p0[j]) begin
                fits = (rob_cred > rob_claim);
                for (int s = 0; s < NUM_ST; s++) begin
                    if (type_p0[j] == STW'(s) && !(st_cred[s] > st_claim[s])) fits = 1'b0;
                end
                if (!blocked && fits) begin
                    issue[j]  = 1'b1;
                    rob_claim = rob_claim + CW'(1);
                    for (int s = 0; s < NUM_ST; s++) begin
                        if (type_p0[j] == STW'(s)) st_claim[s] = st_claim[s] + CW'(1);
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    assign stall    = |(vld_p0 & ~issue);
    assign in_ready = !clear && !stall;
    assign accept   = (|in_valid) && in_ready;

    // Next credit values and over-release detection
    logic [CW:0] st_sum [NUM_ST];
    logic [CW:0] rob_sum;
    logic        over;

    // Combine current credit, claims and release for every counter
    always_comb begin
        rob_sum = credit_sum(rob_cred, rob_claim, rob_release);
        over    = (rob_sum > {1'b0, ROB_FULL});
        for (int s = 0; s < NUM_ST; s++) begin
            st_sum[s] = credit_sum(st_cred[s], st_claim[s], st_release[s*RW +: RW]);
            if (st_sum[s] > {1'b0, ST_FULL}) over = 1'b1;
        end
    end

    // Hold valid bits: reload on accept, otherwise retire the slots that issued
    always_ff @(posedge clock) begin
        if (clear) begin
            vld_p0 <= '0;
        end else if (accept) begin
            vld_p0 <= in_valid;
        end else begin
            vld_p0 <= vld_p0 & ~issue;
        end
    end

    // Hold data: qualified by vld_p0, so it carries no reset
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int j = 0; j < IW; j++) begin
                type_p0[j] <= in_st_type[j*STW +: STW];
                pay_p0[j]  <= in_payload[j*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Issue strobes and upstream stop
    always_ff @(posedge clock) begin
        if (clear) begin
            vld_p1  <= '0;
            stop_p1 <= 1'b0;
        end else begin
            vld_p1  <= issue;
            stop_p1 <= stall;
        end
    end

    // Issued data: don't-care where vld_p1 is low
    always_ff @(posedge clock) begin
        for (int j = 0; j < IW; j++) begin
            type_p1[j] <= type_p0[j];
            pay_p1[j]  <= pay_p0[j];
        end
    end

    // Credit counters: subtract claims, add releases, saturate at depth
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int s = 0; s < NUM_ST; s++) st_cred[s] <= ST_FULL;
            rob_cred <= ROB_FULL;
        end else begin
            for (int s = 0; s < NUM_ST; s++) st_cred[s] <= credit_sat(st_sum[s], ST_FULL);
            rob_cred <= credit_sat(rob_sum, ROB_FULL);
            assert (!over) else $error("credit_issuer: release pushed a credit above depth");
        end
    end

    // Flatten registered state onto the output ports
    always_comb begin
        for (int j = 0; j < IW; j++) begin
            out_st_type[j*STW +: STW]             = type_p1[j];
            out_payload[j*PAYLOAD_W +: PAYLOAD_W] = pay_p1[j];
        end
        for (int s = 0; s < NUM_ST; s++) st_credit[s*CW +: CW] = st_cred[s];
    end

    assign out_valid  = vld_p1;
    assign stop       = stop_p1;
    assign rob_credit = rob_cred;

endmodule

// File: tb/tb_credit_issuer.sv
// tb_credit_issuer: directed cases plus randomized traffic, checked each cycle
// against a slot/credit model of the issue rules kept in the bench.
module tb_credit_issuer;

    localparam int IW  = 2;
    localparam int NS  = 4;
    localparam int SD  = 8;
    localparam int RD  = 32;
    localparam int PW  = 128;
    localparam int STW = 3;
    localparam int CW  = 6;
    localparam int RW  = 2;

    logic               clock = 1'b0;
    logic               reset, flush;
    logic [IW-1:0]      in_valid;
    logic [IW*STW-1:0]  in_st_type;
    logic [IW*PW-1:0]   in_payload;
    logic               in_ready;
    logic [IW-1:0]      out_valid;
    logic [IW*STW-1:0]  out_st_type;
    logic [IW*PW-1:0]   out_payload;
    logic [NS*RW-1:0]   st_release;
    logic [RW-1:0]      rob_release;
    logic [NS*CW-1:0]   st_credit;
    logic [CW-1:0]      rob_credit;
    logic               stop;

    always #5 clock = ~clock;

    credit_issuer #(
        .ISSUE_WIDTH(IW), .NUM_ST(NS), .ST_DEPTH(SD), .ROB_DEPTH(RD), .PAYLOAD_W(PW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_st_type(in_st_type), .in_payload(in_payload),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_st_type(out_st_type), .out_payload(out_payload),
        .st_release(st_release), .rob_release(rob_release),
        .st_credit(st_credit), .rob_credit(rob_credit), .stop(stop)
    );

    // Model state
    bit           mh_v [IW];
    int           mh_t [IW];
    logic [PW-1:0] mh_p [IW];
    bit           m_ov [IW];
    int           m_ot [IW];
    logic [PW-1:0] m_op [IW];
    int           m_st [NS];
    int           m_rob;
    bit           m_stop;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_pay(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pay();
        logic [PW-1:0] p;
        for (int w = 0; w < PW/32; w++) p[w*32 +: 32] = $urandom();
        return p;
    endfunction

    // Which held slots go out this cycle: in order, each needs a free station
    // entry (unless ROB-only) and a free ROB entry after earlier slots' claims.
    function automatic logic [IW-1:0] model_issue();
        int  used_st [NS];
        int  used_rob;
        bit  all_ok;
        bit  fits;
        logic [IW-1:0] r;
        r = '0;
        used_rob = 0;
        all_ok = 1'b1;
        for (int s = 0; s < NS; s++) used_st[s] = 0;
        for (int j = 0; j < IW; j++) begin
            if (mh_v[j]) begin
                fits = (m_rob - used_rob) > 0;
                if (mh_t[j] < NS && (m_st[mh_t[j]] - used_st[mh_t[j]]) <= 0) fits = 1'b0;
                if (all_ok && fits) begin
                    r[j] = 1'b1;
                    used_rob++;
                    if (mh_t[j] < NS) used_st[mh_t[j]]++;
                end else begin
                    all_ok = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic bit model_stall();
        logic [IW-1:0] iss;
        bit st;
        iss = model_issue();
        st = 1'b0;
        for (int j = 0; j < IW; j++) if (mh_v[j] && !iss[j]) st = 1'b1;
        return st;
    endfunction

    task automatic compare_all();
        logic [IW-1:0] ov;
        chk("in_ready", 32'(in_ready), 32'(!(reset || flush) && !model_stall()));
        for (int j = 0; j < IW; j++) ov[j] = m_ov[j];
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("stop", 32'(stop), 32'(m_stop));
        chk("rob_credit", 32'(rob_credit), 32'(m_rob));
        for (int s = 0; s < NS; s++) chk("st_credit", 32'(st_credit[s*CW +: CW]), 32'(m_st[s]));
        for (int j = 0; j < IW; j++) begin
            if (m_ov[j]) begin
                chk("out_st_type", 32'(out_st_type[j*STW +: STW]), 32'(m_ot[j]));
                chk_pay("out_payload", out_payload[j*PW +: PW], m_op[j]);
            end
        end
    endtask

    task automatic model_update();
        logic [IW-1:0] iss;
        bit st;
        int claims [NS];
        int rc;
        int v;
        if (reset || flush) begin
            for (int j = 0; j < IW; j++) begin mh_v[j] = 1'b0; m_ov[j] = 1'b0; end
            m_stop = 1'b0;
            for (int s = 0; s < NS; s++) m_st[s] = SD;
            m_rob = RD;
        end else begin
            iss = model_issue();
            st = model_stall();
            rc = 0;
            for (int s = 0; s < NS; s++) claims[s] = 0;
            for (int j = 0; j < IW; j++) begin
                m_ov[j] = iss[j];
                if (iss[j]) begin
                    m_ot[j] = mh_t[j];
                    m_op[j] = mh_p[j];
                    rc++;
                    if (mh_t[j] < NS) claims[mh_t[j]]++;
                end
            end
            m_stop = st;
            for (int s = 0; s < NS; s++) begin
                v = m_st[s] - claims[s] + int'(st_release[s*RW +: RW]);
                m_st[s] = (v > SD) ? SD : v;
            end
            v = m_rob - rc + int'(rob_release);
            m_rob = (v > RD) ? RD : v;
            if ((|in_valid) && !st) begin
                for (int j = 0; j < IW; j++) begin
                    mh_v[j] = in_valid[j];
                    mh_t[j] = int'(in_st_type[j*STW +: STW]);
                    mh_p[j] = in_payload[j*PW +: PW];
                end
            end else begin
                for (int j = 0; j < IW; j++) if (iss[j]) mh_v[j] = 1'b0;
            end
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; flush = 1'b0; in_valid = '0;
        st_release = '0; rob_release = '0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge clock);
        if (chk_en) compare_all();
        @(posedge clock);
        model_update();
        #1;
        clear_inputs();
        #1;
    endtask

    task automatic bundle(input logic [IW-1:0] v, input int t0, input int t1);
        in_valid   = v;
        in_st_type = {STW'(t1), STW'(t0)};
        in_payload = {rnd_pay(), rnd_pay()};
    endtask

    initial begin
        clear_inputs();
        in_st_type = '0;
        in_payload = '0;
        for (int j = 0; j < IW; j++) begin mh_v[j] = 0; m_ov[j] = 0; mh_t[j] = 0; m_ot[j] = 0; end
        for (int s = 0; s < NS; s++) m_st[s] = SD;
        m_rob = RD; m_stop = 0;

        // Reset state
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst stop", 32'(stop), 32'd0);
        chk("rst rob_credit", 32'(rob_credit), 32'd32);
        chk("rst st_credit ALU", 32'(st_credit[0 +: CW]), 32'd8);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // Case 1: two ALU ops issue two edges after presentation
        bundle(2'b11, 0, 0); step();
        step();
        chk("c1 out_valid", 32'(out_valid), 32'b11);
        chk("c1 st_credit ALU", 32'(st_credit[0 +: CW]), 32'd6);
        chk("c1 rob_credit", 32'(rob_credit), 32'd30);
        chk("c1 stop", 32'(stop), 32'd0);

        // Drain ALU credit down to 1
        bundle(2'b11, 0, 0); step();
        bundle(2'b11, 0, 0); step();
        bundle(2'b11, 0, 4); step();
        step();
        chk("pre2 st_credit ALU", 32'(st_credit[0 +: CW]), 32'd1);
        chk("pre2 rob_credit", 32'(rob_credit), 32'd24);

        // Case 2: only slot0 fits, slot1 waits for a release
        bundle(2'b11, 0, 0); step();
        step();
        chk("c2 out_valid", 32'(out_valid), 32'b01);
        chk("c2 stop", 32'(stop), 32'd1);
        chk("c2 in_ready", 32'(in_ready), 32'd0);
        chk("c2 st_credit ALU", 32'(st_credit[0 +: CW]), 32'd0);
        st_release[0 +: RW] = 2'd1; step();
        step();
        chk("c2 late out_valid", 32'(out_valid), 32'b10);
        chk("c2 late stop", 32'(stop), 32'd0);

        // Case 6: flush while the same kind of stall is held
        bundle(2'b11, 0, 0); st_release[0 +: RW] = 2'd1; step();
        step();
        chk("c6 pre out_valid", 32'(out_valid), 32'b01);
        chk("c6 pre stop", 32'(stop), 32'd1);
        flush = 1'b1; #1;
        chk("c6 in_ready during flush", 32'(in_ready), 32'd0);
        step();
        chk("c6 out_valid", 32'(out_valid), 32'd0);
        chk("c6 stop", 32'(stop), 32'd0);
        chk("c6 rob_credit", 32'(rob_credit), 32'd32);
        chk("c6 st_credit ALU", 32'(st_credit[0 +: CW]), 32'd8);
        chk("c6 in_ready", 32'(in_ready), 32'd1);
        step();
        chk("c6 empty out_valid", 32'(out_valid), 32'd0);

        // Case 3: LS credit empty blocks the whole bundle in order
        for (int k = 0; k < 4; k++) begin bundle(2'b11, 2, 2); step(); end
        bundle(2'b11, 2, 0); step();
        step();
        chk("c3 out_valid", 32'(out_valid), 32'b00);
        chk("c3 st_credit LS", 32'(st_credit[2*CW +: CW]), 32'd0);
        chk("c3 stop", 32'(stop), 32'd1);
        st_release[2*RW +: RW] = 2'd1; step();
        step();
        chk("c3 late out_valid", 32'(out_valid), 32'b11);
        chk("c3 st_credit ALU", 32'(st_credit[0 +: CW]), 32'd7);
        flush = 1'b1; step();

        // Case 4: one ROB entry left
        for (int k = 0; k < 15; k++) begin bundle(2'b11, 4, 4); step(); end
        bundle(2'b01, 4, 0); step();
        bundle(2'b11, 1, 0); step();
        step();
        chk("c4 out_valid", 32'(out_valid), 32'b01);
        chk("c4 rob_credit", 32'(rob_credit), 32'd0);
        rob_release = 2'd2; step();
        step();
        chk("c4 late out_valid", 32'(out_valid), 32'b10);
        chk("c4 late rob_credit", 32'(rob_credit), 32'd1);

        // Case 5: slot0 bubble, slot1 MULT_DIV
        bundle(2'b10, 0, 3); step();
        step();
        chk("c5 out_valid", 32'(out_valid), 32'b10);
        chk("c5 st_credit MD", 32'(st_credit[3*CW +: CW]), 32'd7);
        chk("c5 out_st_type", 32'(out_st_type[STW +: STW]), 32'd3);

        // Randomized traffic with releases bounded by outstanding entries
        for (int c = 0; c < 3000; c++) begin
            int mx;
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 59) == 0);
            bundle(2'($urandom_range(0, 3)), $urandom_range(0, NS), $urandom_range(0, NS));
            for (int s = 0; s < NS; s++) begin
                mx = SD - m_st[s];
                if (mx > 2) mx = 2;
                if ($urandom_range(0, 9) < 3) st_release[s*RW +: RW] = RW'($urandom_range(0, mx));
            end
            mx = RD - m_rob;
            if (mx > 2) mx = 2;
            if ($urandom_range(0, 9) < 4) rob_release = RW'($urandom_range(0, mx));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
